// File: rtl/hsm_pin_link_if.sv
// Bundles the host byte-stream side and the pin-transceiver side of hsm_pin_link.
// The link engine is the slave; the host/peer model (or bench) is the master.
interface hsm_pin_link_if #(
    parameter int unsigned DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] tx_data;
    logic                  tx_valid;
    logic                  tx_ready;
    logic                  rd_en;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic                  pin_dir;
    logic [DATA_WIDTH-1:0] pin_tx_data;
    logic [DATA_WIDTH-1:0] pin_rx_data;
    logic                  wr_stb;
    logic                  rd_req;
    logic                  peer_ack;
    logic                  busy;
    logic                  err;

    modport master (
        output tx_data, tx_valid, rd_en, rx_ready, pin_rx_data, peer_ack,
        input  tx_ready, rx_data, rx_valid, pin_dir, pin_tx_data, wr_stb, rd_req, busy, err
    );

    modport slave (
        input  tx_data, tx_valid, rd_en, rx_ready, pin_rx_data, peer_ack,
        output tx_ready, rx_data, rx_valid, pin_dir, pin_tx_data, wr_stb, rd_req, busy, err
    );
endinterface

// File: rtl/hsm_pin_link.sv
// Half-duplex strobed parallel pin protocol engine: TX FIFO feeding strobed writes,
// request/acknowledge reads into a single holding register, and a peer-silence timeout.
module hsm_pin_link #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned TX_DEPTH   = 4,
    parameter int unsigned SETUP_CYC  = 2,
    parameter int unsigned STB_CYC    = 2,
    parameter int unsigned TIMEOUT    = 255
) (
    input logic           clk,
    input logic           rst_n,
    hsm_pin_link_if.slave bus
);
    localparam int unsigned PTR_W   = (TX_DEPTH > 1) ? $clog2(TX_DEPTH) : 1;
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned TMR_MX0 = (SETUP_CYC > STB_CYC) ? SETUP_CYC : STB_CYC;
    localparam int unsigned TMR_MAX = (TMR_MX0 > TIMEOUT) ? TMR_MX0 : TIMEOUT;
    localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

    localparam logic [TMR_W-1:0] SETUP_LAST = TMR_W'(SETUP_CYC - 1);
    localparam logic [TMR_W-1:0] STB_LAST   = TMR_W'(STB_CYC - 1);
    localparam logic [TMR_W-1:0] TO_LAST    = TMR_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] FULL_CNT   = CNT_W'(TX_DEPTH);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WR_LOAD    = 3'd1;
    localparam logic [2:0] WR_SETUP   = 3'd2;
    localparam logic [2:0] WR_STROBE  = 3'd3;
    localparam logic [2:0] WR_HOLD    = 3'd4;
    localparam logic [2:0] RD_TURN    = 3'd5;
    localparam logic [2:0] RD_REQ     = 3'd6;
    localparam logic [2:0] RD_RELEASE = 3'd7;

    logic [2:0]            state_q, state_d;
    logic [TMR_W-1:0]      tmr_q, tmr_d;
    logic [DATA_WIDTH-1:0] mem [TX_DEPTH];
    logic [PTR_W-1:0]      wptr_q, rptr_q;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  tx_ready_q;
    logic                  pin_dir_q, pin_dir_d;
    logic [DATA_WIDTH-1:0] pin_tx_data_q, pin_tx_data_d;
    logic                  wr_stb_q, wr_stb_d;
    logic                  rd_req_q, rd_req_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                  rx_valid_q, rx_valid_d;
    logic                  err_q, err_d;
    logic                  busy_q;
    logic                  ack_meta_q, ack_sync_q;
    logic                  push, pop;

    // tx_ready comes from the registered count, so a full FIFO refuses a push even on a pop
    assign push = bus.tx_valid && tx_ready_q;

    // Next-state logic for the protocol FSM and its registered outputs
    always_comb begin
        state_d       = state_q;
        tmr_d         = tmr_q;
        pin_dir_d     = pin_dir_q;
        pin_tx_data_d = pin_tx_data_q;
        wr_stb_d      = wr_stb_q;
        rd_req_d      = rd_req_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = rx_valid_q;
        err_d         = 1'b0;
        pop           = 1'b0;
        if (rx_valid_q && bus.rx_ready) begin
            rx_valid_d = 1'b0;
        end
        unique case (state_q)
            IDLE: begin
                // A byte arriving this cycle still beats a read
                if (count_q != '0) begin
                    state_d = WR_LOAD;
                end else if (bus.rd_en && !rx_valid_q && !push) begin
                    state_d   = RD_TURN;
                    pin_dir_d = 1'b1;
                end
            end
            WR_LOAD: begin
                pop           = 1'b1;
                pin_tx_data_d = mem[rptr_q];
                pin_dir_d     = 1'b0;
                tmr_d         = '0;
                state_d       = WR_SETUP;
            end
            WR_SETUP: begin
                if (tmr_q == SETUP_LAST) begin
                    tmr_d    = '0;
                    wr_stb_d = 1'b1;
                    state_d  = WR_STROBE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            WR_STROBE: begin
                if (tmr_q == STB_LAST) begin
                    wr_stb_d = 1'b0;
                    state_d  = WR_HOLD;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            WR_HOLD: begin
                state_d = IDLE;
            end
            RD_TURN: begin
                rd_req_d = 1'b1;
                tmr_d    = '0;
                state_d  = RD_REQ;
            end
            RD_REQ: begin
                if (ack_sync_q) begin
                    rx_data_d  = bus.pin_rx_data;
                    rx_valid_d = 1'b1;
                    rd_req_d   = 1'b0;
                    tmr_d      = '0;
                    state_d    = RD_RELEASE;
                end else if (tmr_q == TO_LAST) begin
                    err_d    = 1'b1;
                    rd_req_d = 1'b0;
                    state_d  = IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            RD_RELEASE: begin
                if (!ack_sync_q) begin
                    state_d = IDLE;
                end else if (tmr_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = IDLE;
                end else begin
                    tmr_d = tmr_q + TMR_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // FIFO occupancy after this cycle's push/pop
    always_comb begin
        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // FIFO storage; contents need no reset since the count gates every read
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= bus.tx_data;
        end
    end

    // Control state, FIFO pointers, ack synchroniser and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            tmr_q         <= '0;
            wptr_q        <= '0;
            rptr_q        <= '0;
            count_q       <= '0;
            tx_ready_q    <= 1'b1;
            pin_dir_q     <= 1'b1;
            pin_tx_data_q <= '0;
            wr_stb_q      <= 1'b0;
            rd_req_q      <= 1'b0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            err_q         <= 1'b0;
            busy_q        <= 1'b0;
            ack_meta_q    <= 1'b0;
            ack_sync_q    <= 1'b0;
        end else begin
            state_q       <= state_d;
            tmr_q         <= tmr_d;
            if (push) wptr_q <= wptr_q + PTR_W'(1);
            if (pop)  rptr_q <= rptr_q + PTR_W'(1);
            count_q       <= count_d;
            tx_ready_q    <= (count_d != FULL_CNT);
            pin_dir_q     <= pin_dir_d;
            pin_tx_data_q <= pin_tx_data_d;
            wr_stb_q      <= wr_stb_d;
            rd_req_q      <= rd_req_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            err_q         <= err_d;
            busy_q        <= (state_d != IDLE);
            ack_meta_q    <= bus.peer_ack;
            ack_sync_q    <= ack_meta_q;
        end
    end

    assign bus.tx_ready    = tx_ready_q;
    assign bus.pin_dir     = pin_dir_q;
    assign bus.pin_tx_data = pin_tx_data_q;
    assign bus.wr_stb      = wr_stb_q;
    assign bus.rd_req      = rd_req_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.err         = err_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_hsm_pin_link.sv
// Self-checking bench for hsm_pin_link: write timeline table, FIFO fill, async reset,
// read handshake, timeout and write-over-read priority, with write/read scoreboards.
module tb_hsm_pin_link;
    localparam int unsigned DW = 8;
    localparam int unsigned TO = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    hsm_pin_link_if #(.DATA_WIDTH(DW)) bus ();

    hsm_pin_link #(
        .DATA_WIDTH(DW),
        .TX_DEPTH  (4),
        .SETUP_CYC (2),
        .STB_CYC   (2),
        .TIMEOUT   (TO)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    typedef struct {
        logic          stb;
        logic          dir;
        logic          busy;
        logic          rdy;
        logic [DW-1:0] data;
    } wr_row_t;

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    logic [DW-1:0] wr_sb[$];
    logic [DW-1:0] rx_sb[$];
    int stb_cyc[$];
    int rdreq_cyc[$];
    logic prev_stb = 1'b0, prev_rdreq = 1'b0, prev_dir = 1'b1, prev_rxv = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard side: compare strobed bytes and captured bytes as the DUT produces them
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.wr_stb && !prev_stb) begin
                stb_cyc.push_back(cyc);
                if (wr_sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_strobe: data 0x%0h, none queued", bus.pin_tx_data);
                end else begin
                    check("wr_data", bus.pin_tx_data, wr_sb.pop_front());
                end
                check("wr_dir", bus.pin_dir, 0);
            end
            if (bus.rd_req && !prev_rdreq) begin
                rdreq_cyc.push_back(cyc);
                check("turnaround_dir", prev_dir, 1);
            end
            if (bus.rx_valid && !prev_rxv) begin
                if (rx_sb.size() == 0) begin
                    n_total++;
                    $display("FAIL unexpected_rx: data 0x%0h, none queued", bus.rx_data);
                end else begin
                    check("rx_data", bus.rx_data, rx_sb.pop_front());
                end
            end
        end
        prev_stb   <= bus.wr_stb;
        prev_rdreq <= bus.rd_req;
        prev_dir   <= bus.pin_dir;
        prev_rxv   <= bus.rx_valid;
    end

    initial begin
        wr_row_t tl[8];
        int t;
        int c0;
        int r;
        int a;
        int base;
        int nrd;

        // Single write accepted in cycle k; row j is cycle k+1+j
        tl[0] = '{stb: 0, dir: 1, busy: 0, rdy: 1, data: 8'h00};
        tl[1] = '{stb: 0, dir: 1, busy: 1, rdy: 1, data: 8'h00};
        tl[2] = '{stb: 0, dir: 0, busy: 1, rdy: 1, data: 8'hA5};
        tl[3] = '{stb: 0, dir: 0, busy: 1, rdy: 1, data: 8'hA5};
        tl[4] = '{stb: 1, dir: 0, busy: 1, rdy: 1, data: 8'hA5};
        tl[5] = '{stb: 1, dir: 0, busy: 1, rdy: 1, data: 8'hA5};
        tl[6] = '{stb: 0, dir: 0, busy: 1, rdy: 1, data: 8'hA5};
        tl[7] = '{stb: 0, dir: 0, busy: 0, rdy: 1, data: 8'hA5};

        bus.tx_data = '0;
        bus.tx_valid = 1'b0;
        bus.rd_en = 1'b0;
        bus.rx_ready = 1'b0;
        bus.pin_rx_data = '0;
        bus.peer_ack = 1'b0;

        // Reset values
        #1 rst_n = 1'b0;
        repeat (3) tick();
        check("rst_pin_dir", bus.pin_dir, 1);
        check("rst_pin_tx_data", bus.pin_tx_data, 0);
        check("rst_wr_stb", bus.wr_stb, 0);
        check("rst_rd_req", bus.rd_req, 0);
        check("rst_tx_ready", bus.tx_ready, 1);
        check("rst_rx_valid", bus.rx_valid, 0);
        check("rst_rx_data", bus.rx_data, 0);
        check("rst_err", bus.err, 0);
        check("rst_busy", bus.busy, 0);
        rst_n = 1'b1;
        repeat (2) tick();

        // Single write timeline
        check("w1_ready", bus.tx_ready, 1);
        bus.tx_data = 8'hA5;
        bus.tx_valid = 1'b1;
        wr_sb.push_back(8'hA5);
        tick();
        bus.tx_valid = 1'b0;
        for (int j = 0; j < 8; j++) begin
            check($sformatf("w1_stb_k%0d", j + 1), bus.wr_stb, tl[j].stb);
            check($sformatf("w1_dir_k%0d", j + 1), bus.pin_dir, tl[j].dir);
            check($sformatf("w1_busy_k%0d", j + 1), bus.busy, tl[j].busy);
            check($sformatf("w1_rdy_k%0d", j + 1), bus.tx_ready, tl[j].rdy);
            check($sformatf("w1_data_k%0d", j + 1), bus.pin_tx_data, tl[j].data);
            if (j < 7) tick();
        end

        // Fill the FIFO with 5 back-to-back bytes
        base = stb_cyc.size();
        c0 = cyc;
        for (int i = 0; i < 5; i++) begin
            check($sformatf("fill_ready_%0d", i), bus.tx_ready, 1);
            bus.tx_data = 8'(i + 1);
            bus.tx_valid = 1'b1;
            wr_sb.push_back(8'(i + 1));
            tick();
        end
        bus.tx_valid = 1'b0;
        check("fill_full", bus.tx_ready, 0);
        repeat (4) tick();
        check("fill_still_full", bus.tx_ready, 0);
        tick();
        check("fill_ready_again", bus.tx_ready, 1);
        t = 0;
        while (stb_cyc.size() < base + 5 && t < 60) begin tick(); t++; end
        check("fill_strobe_count", stb_cyc.size() - base, 5);
        if (stb_cyc.size() >= base + 5) begin
            check("fill_first_strobe", stb_cyc[base] - c0, 5);
            for (int i = 1; i < 5; i++)
                check($sformatf("fill_spacing_%0d", i), stb_cyc[base+i] - stb_cyc[base+i-1], 7);
        end
        t = 0;
        while (bus.busy && t < 10) begin tick(); t++; end
        check("fill_idle", bus.busy, 0);

        // Asynchronous reset in the middle of a strobe discards queued bytes
        for (int i = 0; i < 3; i++) begin
            bus.tx_data = 8'hB1 + 8'(i);
            bus.tx_valid = 1'b1;
            wr_sb.push_back(8'hB1 + 8'(i));
            tick();
        end
        bus.tx_valid = 1'b0;
        t = 0;
        while (!bus.wr_stb && t < 12) begin tick(); t++; end
        check("rst_mid_saw_strobe", bus.wr_stb, 1);
        @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_wr_stb", bus.wr_stb, 0);
        check("rst_mid_pin_dir", bus.pin_dir, 1);
        check("rst_mid_tx_ready", bus.tx_ready, 1);
        check("rst_mid_busy", bus.busy, 0);
        check("rst_mid_data", bus.pin_tx_data, 0);
        wr_sb.delete();
        tick();
        tick();
        rst_n = 1'b1;
        base = stb_cyc.size();
        repeat (30) tick();
        check("rst_discard_no_strobe", stb_cyc.size() - base, 0);
        check("rst_discard_idle", bus.busy, 0);

        // Read with the peer acking 10 cycles after rd_req
        bus.rd_en = 1'b1;
        t = 0;
        while (!bus.rd_req && t < 10) begin tick(); t++; end
        check("rd_req_rise", bus.rd_req, 1);
        check("rd_req_dir", bus.pin_dir, 1);
        repeat (10) tick();
        check("rd_req_held", bus.rd_req, 1);
        bus.pin_rx_data = 8'h3C;
        bus.peer_ack = 1'b1;
        rx_sb.push_back(8'h3C);
        a = cyc;
        t = 0;
        while (!bus.rx_valid && t < 8) begin tick(); t++; end
        check("rd_rx_valid", bus.rx_valid, 1);
        check("rd_capture_lat_2to3", (cyc - a >= 2) && (cyc - a <= 3), 1);
        check("rd_req_cleared", bus.rd_req, 0);
        bus.peer_ack = 1'b0;
        t = 0;
        while (bus.busy && t < 8) begin tick(); t++; end
        check("rd_release_idle", bus.busy, 0);
        nrd = rdreq_cyc.size();
        repeat (20) tick();
        check("rd_blocked_no_req", rdreq_cyc.size() - nrd, 0);
        check("rd_blocked_valid", bus.rx_valid, 1);
        check("rd_blocked_data", bus.rx_data, 8'h3C);
        bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
        check("rd_consumed", bus.rx_valid, 0);

        // Next read is never acked and times out
        t = 0;
        while (!bus.rd_req && t < 10) begin tick(); t++; end
        check("to_req_rise", bus.rd_req, 1);
        r = cyc;
        t = 0;
        while (!bus.err && t < 40) begin tick(); t++; end
        check("to_err_seen", bus.err, 1);
        check("to_err_delay", cyc - r, TO);
        check("to_rd_req_low", bus.rd_req, 0);
        check("to_no_rx_valid", bus.rx_valid, 0);
        tick();
        check("to_err_single", bus.err, 0);
        t = 0;
        while (!bus.rd_req && t < 6) begin tick(); t++; end
        check("to_restart_req", bus.rd_req, 1);
        bus.rd_en = 1'b0;
        t = 0;
        while (!bus.err && t < 30) begin tick(); t++; end
        check("to_second_err", bus.err, 1);
        t = 0;
        while (bus.busy && t < 5) begin tick(); t++; end
        check("to_idle", bus.busy, 0);

        // Write and read requested together: write first, then turnaround
        base = stb_cyc.size();
        bus.tx_data = 8'hC3;
        bus.tx_valid = 1'b1;
        bus.rd_en = 1'b1;
        wr_sb.push_back(8'hC3);
        tick();
        bus.tx_valid = 1'b0;
        t = 0;
        while (!bus.rd_req && t < 20) begin tick(); t++; end
        check("pri_req_rise", bus.rd_req, 1);
        check("pri_write_done", stb_cyc.size() - base, 1);
        if (stb_cyc.size() > base) check("pri_write_before_read", stb_cyc[$] < cyc, 1);
        bus.pin_rx_data = 8'h5A;
        bus.peer_ack = 1'b1;
        rx_sb.push_back(8'h5A);
        t = 0;
        while (!bus.rx_valid && t < 8) begin tick(); t++; end
        check("pri_rx_valid", bus.rx_valid, 1);
        bus.peer_ack = 1'b0;
        bus.rd_en = 1'b0;
        bus.rx_ready = 1'b1;
        tick();
        bus.rx_ready = 1'b0;
        t = 0;
        while (bus.busy && t < 10) begin tick(); t++; end
        check("pri_idle", bus.busy, 0);

        repeat (3) tick();
        check("wr_sb_drained", wr_sb.size(), 0);
        check("rx_sb_drained", rx_sb.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
